// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one sram-like memory port between instruction
// fetch (port i) and data access (port d). Address-phase requests are
// arbitrated and held until accepted, and an owner FIFO routes each
// data_ok/rdata back to the requester that issued the transaction.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternating priority on ties);
// when undefined, data access always wins over fetch.
module sram_like_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic        arb_err
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PW-1:0] PTR_LAST   = PW'(MAX_OUTSTANDING - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(MAX_OUTSTANDING);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state_reg;
  logic          grant_d_reg;
  logic [CW-1:0] count_reg;
  logic [PW-1:0] wptr_reg;
  logic [PW-1:0] rptr_reg;
  logic          owner_mem [MAX_OUTSTANDING];
  logic          arb_err_reg;
`ifdef ARB_ROUND_ROBIN_EN
  logic          last_grant_reg;  // 1 = d owned the most recent handshake
`endif

  logic full;
  logic pick_d;
  logic req_c;
  logic owner_c;     // 1 = d, 0 = i
  logic push;
  logic pop;
  logic head_owner;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Select the owner of the memory port this cycle (held owner wins in HOLD)
  always_comb begin
    full = (count_reg == COUNT_FULL);
`ifdef ARB_ROUND_ROBIN_EN
    // On a tie, the requester that did not win last time goes first
    pick_d = d_req & ~(i_req & last_grant_reg);
`else
    pick_d = d_req;
`endif
    req_c   = 1'b0;
    owner_c = 1'b0;
    if (state_reg == HOLD) begin
      req_c   = 1'b1;
      owner_c = grant_d_reg;
    end else if (!full && (d_req || i_req)) begin
      req_c   = 1'b1;
      owner_c = pick_d;
    end
  end

  // Forward the owner's request fields onto the memory port, zero when idle
  always_comb begin
    m_req   = req_c;
    m_wr    = 1'b0;
    m_size  = 2'd0;
    m_addr  = 32'd0;
    m_wstrb = 4'd0;
    m_wdata = 32'd0;
    if (req_c) begin
      if (owner_c) begin
        m_wr    = d_wr;
        m_size  = d_size;
        m_addr  = d_addr;
        m_wstrb = d_wstrb;
        m_wdata = d_wdata;
      end else begin
        m_size  = 2'd2;
        m_addr  = i_addr;
      end
    end
  end

  assign push       = req_c & m_addr_ok;
  assign pop        = m_data_ok & (count_reg != '0);
  assign head_owner = owner_mem[rptr_reg];

  assign i_addr_ok = push & ~owner_c;
  assign d_addr_ok = push & owner_c;
  assign i_data_ok = pop & ~head_owner;
  assign d_data_ok = pop & head_owner;
  assign i_rdata   = i_data_ok ? m_rdata : 32'd0;
  assign d_rdata   = d_data_ok ? m_rdata : 32'd0;
  assign arb_err   = arb_err_reg;

  // Address-phase FSM: park in HOLD until the memory accepts the request
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      grant_d_reg    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_c && !m_addr_ok) begin
            state_reg   <= HOLD;
            grant_d_reg <= owner_c;
          end
        end
        HOLD: begin
          if (m_addr_ok) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
`ifdef ARB_ROUND_ROBIN_EN
      if (push) begin
        last_grant_reg <= owner_c;
      end
`endif
    end
  end

  // Owner storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      owner_mem[wptr_reg] <= owner_c;
    end
  end

  // Owner FIFO pointers and occupancy; a pop and push together keep count
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) begin
        wptr_reg <= ptr_inc(wptr_reg);
      end
      if (pop) begin
        rptr_reg <= ptr_inc(rptr_reg);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Sticky flag for a data response that has no transaction to belong to
  always_ff @(posedge clk) begin
    if (reset) begin
      arb_err_reg <= 1'b0;
    end else if (m_data_ok && (count_reg == '0)) begin
      arb_err_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_sram_like_arbiter;

  localparam int MAXO = 2;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_addr_ok, i_data_ok;
  logic [31:0] i_rdata;
  logic        d_req, d_wr;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [3:0]  d_wstrb;
  logic [31:0] d_wdata;
  logic        d_addr_ok, d_data_ok;
  logic [31:0] d_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [3:0]  m_wstrb;
  logic [31:0] m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;
  logic        arb_err;

  int n_vec = 0;
  int n_bad = 0;

  sram_like_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
    .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
    .d_wstrb(d_wstrb), .d_wdata(d_wdata), .d_addr_ok(d_addr_ok),
    .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
    .m_wstrb(m_wstrb), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok),
    .m_data_ok(m_data_ok), .m_rdata(m_rdata), .arb_err(arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int oq[$];        // owners of accepted, unanswered transactions (1 = d)
  int held = -1;    // owner waiting for addr_ok, -1 if none
  bit merr = 0;
  int mlast = 0;    // owner of most recent handshake

  logic        e_req, e_wr, e_iaok, e_daok, e_idok, e_ddok, e_err;
  logic [1:0]  e_size;
  logic [3:0]  e_wstrb;
  logic [31:0] e_addr, e_wdata, e_ird, e_drd;
  int          e_owner;

  task automatic model_eval();
    e_req = 0; e_wr = 0; e_size = 0; e_addr = 0; e_wstrb = 0; e_wdata = 0;
    e_iaok = 0; e_daok = 0; e_idok = 0; e_ddok = 0; e_ird = 0; e_drd = 0;
    e_owner = 0;
    if (held >= 0) begin
      e_req = 1; e_owner = held;
    end else if (oq.size() < MAXO && (d_req || i_req)) begin
      e_req = 1;
`ifdef ARB_ROUND_ROBIN_EN
      if (d_req && i_req) e_owner = (mlast == 1) ? 0 : 1;
      else e_owner = d_req ? 1 : 0;
`else
      e_owner = d_req ? 1 : 0;
`endif
    end
    if (e_req) begin
      if (e_owner == 1) begin
        e_wr = d_wr; e_size = d_size; e_addr = d_addr;
        e_wstrb = d_wstrb; e_wdata = d_wdata;
      end else begin
        e_size = 2; e_addr = i_addr;
      end
    end
    e_iaok = e_req && m_addr_ok && (e_owner == 0);
    e_daok = e_req && m_addr_ok && (e_owner == 1);
    if (m_data_ok && oq.size() > 0) begin
      if (oq[0] == 1) begin e_ddok = 1; e_drd = m_rdata; end
      else begin e_idok = 1; e_ird = m_rdata; end
    end
    e_err = merr;
  endtask

  task automatic model_commit();
    if (reset) begin
      oq.delete(); held = -1; merr = 0; mlast = 0;
    end else begin
      if (m_data_ok) begin
        if (oq.size() > 0) void'(oq.pop_front());
        else merr = 1;
      end
      if (e_req && m_addr_ok) begin
        oq.push_back(e_owner); mlast = e_owner; held = -1;
      end else if (e_req) begin
        held = e_owner;
      end
    end
  endtask

  // advance one clock: model sees the same inputs the DUT samples
  task automatic tick();
    @(posedge clk);
    model_eval();
    model_commit();
    #1;
  endtask

  task automatic settle();
    model_eval();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_req = 0; i_addr = 0; d_req = 0; d_wr = 0; d_size = 0; d_addr = 0;
    d_wstrb = 0; d_wdata = 0; m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic d_load(input logic [31:0] a);
    d_req = 1; d_wr = 0; d_size = 2; d_addr = a; d_wstrb = 0; d_wdata = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    settle();
    n_vec++;
    if ({m_req, m_wr, m_size, m_addr, m_wstrb, m_wdata} !== 72'd0) begin
      n_bad++; $display("FAIL reset_mport got req=%b addr=%h required all zero", m_req, m_addr);
    end
    n_vec++;
    if ({i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, arb_err} !== 5'd0 || i_rdata !== 0 || d_rdata !== 0) begin
      n_bad++; $display("FAIL reset_outputs got iaok=%b idok=%b daok=%b ddok=%b err=%b required 0",
                        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, arb_err);
    end
    tick();
  endtask

  task automatic test_priority();
    do_reset();
    d_load(32'h1000); i_req = 1; i_addr = 32'h1c000000; m_addr_ok = 1;
    settle();
    n_vec++;
    if (d_addr_ok !== 1 || i_addr_ok !== 0 || m_addr !== 32'h1000) begin
      n_bad++; $display("FAIL prio_cycle0 got daok=%b iaok=%b addr=%h required 1 0 00001000", d_addr_ok, i_addr_ok, m_addr);
    end
    tick(); d_req = 0;
    settle();
    n_vec++;
    if (i_addr_ok !== 1 || d_addr_ok !== 0 || m_addr !== 32'h1c000000) begin
      n_bad++; $display("FAIL prio_cycle1 got iaok=%b daok=%b addr=%h required 1 0 1c000000", i_addr_ok, d_addr_ok, m_addr);
    end
    tick(); i_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'hAAAA5555;
    settle();
    n_vec++;
    if (d_data_ok !== 1 || d_rdata !== 32'hAAAA5555 || i_data_ok !== 0 || i_rdata !== 0) begin
      n_bad++; $display("FAIL prio_ret_d got ddok=%b drd=%h idok=%b ird=%h required 1 aaaa5555 0 0",
                        d_data_ok, d_rdata, i_data_ok, i_rdata);
    end
    tick(); m_rdata = 32'h12345678;
    settle();
    n_vec++;
    if (i_data_ok !== 1 || i_rdata !== 32'h12345678 || d_data_ok !== 0 || d_rdata !== 0) begin
      n_bad++; $display("FAIL prio_ret_i got idok=%b ird=%h ddok=%b drd=%h required 1 12345678 0 0",
                        i_data_ok, i_rdata, d_data_ok, d_rdata);
    end
    tick(); m_data_ok = 0;
  endtask

  task automatic test_hold();
    do_reset();
    i_req = 1; i_addr = 32'h1c000000; m_addr_ok = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) d_load(32'h3000);
      m_addr_ok = (c == 3);
      settle();
      n_vec++;
      if (m_req !== 1 || m_addr !== 32'h1c000000 || i_addr_ok !== (c == 3) || d_addr_ok !== 0) begin
        n_bad++; $display("FAIL hold_c%0d got req=%b addr=%h iaok=%b daok=%b required addr 1c000000 iaok=%0d",
                          c, m_req, m_addr, i_addr_ok, d_addr_ok, (c == 3));
      end
      tick();
    end
    i_req = 0; m_addr_ok = 1;
    settle();
    n_vec++;
    if (d_addr_ok !== 1 || m_addr !== 32'h3000) begin
      n_bad++; $display("FAIL hold_then_d got daok=%b addr=%h required 1 00003000", d_addr_ok, m_addr);
    end
    tick(); d_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h0000_0111;
    settle();
    n_vec++;
    if (i_data_ok !== 1 || d_data_ok !== 0) begin
      n_bad++; $display("FAIL hold_drain_i got idok=%b ddok=%b required 1 0", i_data_ok, d_data_ok);
    end
    tick(); m_rdata = 32'h0000_0222;
    settle();
    n_vec++;
    if (d_data_ok !== 1 || d_rdata !== 32'h222 || i_data_ok !== 0) begin
      n_bad++; $display("FAIL hold_drain_d got ddok=%b drd=%h idok=%b required 1 00000222 0", d_data_ok, d_rdata, i_data_ok);
    end
    tick(); m_data_ok = 0;
  endtask

  task automatic test_full();
    do_reset();
    m_addr_ok = 1;
    for (int k = 0; k < 2; k++) begin
      d_load(32'h100 + 32'(4 * k));
      settle();
      n_vec++;
      if (d_addr_ok !== 1) begin
        n_bad++; $display("FAIL full_fill%0d got daok=%b required 1", k, d_addr_ok);
      end
      tick();
    end
    d_load(32'h108);
    settle();
    n_vec++;
    if (m_req !== 0 || d_addr_ok !== 0) begin
      n_bad++; $display("FAIL full_block got req=%b daok=%b required 0 0", m_req, d_addr_ok);
    end
    tick(); m_data_ok = 1; m_rdata = 32'h5a5a0001;
    settle();
    n_vec++;
    if (d_data_ok !== 1 || m_req !== 0) begin
      n_bad++; $display("FAIL full_pop got ddok=%b req=%b required 1 0", d_data_ok, m_req);
    end
    tick(); m_data_ok = 0;
    settle();
    n_vec++;
    if (m_req !== 1 || d_addr_ok !== 1 || m_addr !== 32'h108) begin
      n_bad++; $display("FAIL full_resume got req=%b daok=%b addr=%h required 1 1 00000108", m_req, d_addr_ok, m_addr);
    end
    tick(); d_req = 0;
  endtask

  task automatic test_store();
    do_reset();
    d_req = 1; d_wr = 1; d_size = 0; d_wstrb = 4'b0100; d_wdata = 32'h00EF0000;
    d_addr = 32'h2002; m_addr_ok = 1;
    settle();
    n_vec++;
    if (m_req !== 1 || m_wr !== 1 || m_size !== 0 || m_wstrb !== 4'b0100 ||
        m_wdata !== 32'h00EF0000 || m_addr !== 32'h2002 || d_addr_ok !== 1) begin
      n_bad++; $display("FAIL store_fields got req=%b wr=%b size=%0d strb=%b wdata=%h addr=%h daok=%b required 1 1 0 0100 00ef0000 00002002 1",
                        m_req, m_wr, m_size, m_wstrb, m_wdata, m_addr, d_addr_ok);
    end
    tick(); d_req = 0; d_wr = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 0;
    settle();
    n_vec++;
    if (d_data_ok !== 1 || i_data_ok !== 0) begin
      n_bad++; $display("FAIL store_resp got ddok=%b idok=%b required 1 0", d_data_ok, i_data_ok);
    end
    tick(); m_data_ok = 0;
  endtask

  task automatic test_spurious_reset();
    do_reset();
    m_data_ok = 1; m_rdata = 32'hDEADBEEF;
    settle();
    n_vec++;
    if (i_data_ok !== 0 || d_data_ok !== 0 || i_rdata !== 0 || d_rdata !== 0) begin
      n_bad++; $display("FAIL spur_no_dataok got idok=%b ddok=%b ird=%h drd=%h required 0", i_data_ok, d_data_ok, i_rdata, d_rdata);
    end
    tick(); m_data_ok = 0;
    settle();
    n_vec++;
    if (arb_err !== 1) begin
      n_bad++; $display("FAIL spur_err got arb_err=%b required 1", arb_err);
    end
    tick(); i_req = 1; i_addr = 32'h1c000040; m_addr_ok = 0;
    tick();
    settle();
    n_vec++;
    if (m_req !== 1 || m_addr !== 32'h1c000040 || arb_err !== 1) begin
      n_bad++; $display("FAIL spur_hold got req=%b addr=%h err=%b required 1 1c000040 1", m_req, m_addr, arb_err);
    end
    reset = 1; i_req = 0; i_addr = 0;
    tick(); reset = 0;
    settle();
    n_vec++;
    if (m_req !== 0 || arb_err !== 0 || m_addr !== 0) begin
      n_bad++; $display("FAIL reset_midhold got req=%b err=%b addr=%h required 0 0 0", m_req, arb_err, m_addr);
    end
    tick(); m_data_ok = 1; m_rdata = 32'h1;
    settle();
    n_vec++;
    if (i_data_ok !== 0 || d_data_ok !== 0) begin
      n_bad++; $display("FAIL reset_forgets got idok=%b ddok=%b required 0 0", i_data_ok, d_data_ok);
    end
    tick(); m_data_ok = 0;
    settle();
    n_vec++;
    if (arb_err !== 1) begin
      n_bad++; $display("FAIL reset_count0 got arb_err=%b required 1", arb_err);
    end
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    d_load(32'h4000); i_req = 1; i_addr = 32'h1c000100; m_addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
      m_data_ok = (k > 0); m_rdata = 32'(k);
      settle();
`ifdef ARB_ROUND_ROBIN_EN
      n_vec++;
      if (d_addr_ok !== (k % 2 == 0) || i_addr_ok !== (k % 2 == 1)) begin
        n_bad++; $display("FAIL rr_grant%0d got daok=%b iaok=%b required daok=%0d", k, d_addr_ok, i_addr_ok, (k % 2 == 0));
      end
`else
      n_vec++;
      if (d_addr_ok !== 1 || i_addr_ok !== 0) begin
        n_bad++; $display("FAIL fixed_grant%0d got daok=%b iaok=%b required 1 0", k, d_addr_ok, i_addr_ok);
      end
`endif
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_random();
    bit i_pend = 0, d_pend = 0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (!i_pend && $urandom_range(0, 1) == 1) begin
        i_pend = 1; i_addr = $urandom & 32'hfffffffc;
      end
      if (!d_pend && $urandom_range(0, 1) == 1) begin
        d_pend = 1; d_wr = 1'($urandom); d_size = 2'($urandom_range(0, 2));
        d_addr = $urandom; d_wstrb = 4'($urandom); d_wdata = $urandom;
      end
      i_req = i_pend; d_req = d_pend;
      m_addr_ok = ($urandom_range(0, 9) < 6);
      m_data_ok = (oq.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 99) < 2);
      m_rdata = $urandom;
      settle();
      n_vec++;
      if ({m_req, m_wr, m_size, m_addr, m_wstrb, m_wdata} !== {e_req, e_wr, e_size, e_addr, e_wstrb, e_wdata} ||
          {i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, arb_err} !== {e_iaok, e_daok, e_idok, e_ddok, e_err} ||
          i_rdata !== e_ird || d_rdata !== e_drd) begin
        n_bad++;
        $display("FAIL rand_%0d got req=%b wr=%b sz=%0d a=%h st=%h wd=%h ok=%b%b%b%b err=%b ird=%h drd=%h required req=%b wr=%b sz=%0d a=%h st=%h wd=%h ok=%b%b%b%b err=%b ird=%h drd=%h",
                 n, m_req, m_wr, m_size, m_addr, m_wstrb, m_wdata, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, arb_err, i_rdata, d_rdata,
                 e_req, e_wr, e_size, e_addr, e_wstrb, e_wdata, e_iaok, e_daok, e_idok, e_ddok, e_err, e_ird, e_drd);
      end
      tick();
      if (reset) begin
        i_pend = 0; d_pend = 0;
      end else begin
        if (e_iaok) i_pend = 0;
        if (e_daok) d_pend = 0;
      end
    end
    reset = 0;
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_priority();
    test_hold();
    test_full();
    test_store();
    test_spurious_reset();
    test_round_robin();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one sram-like memory port between two requesters: instruction fetch (IF stage, port "i") and data access (EXE/MEM stage, port "d").
- Arbitrates address-phase requests and holds the granted request stable until the memory accepts it.
- Tracks outstanding transactions in an owner FIFO and routes each data_ok/rdata back to the requester that issued it.
- Sits between the pipeline's inst/data sram-like interfaces and the memory-side bridge.

Parameters:
- MAX_OUTSTANDING, 2: depth of the owner FIFO. Legal values 1..4.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- i_req  input  1  fetch request valid.
- i_addr  input  32  fetch address.
- i_addr_ok  output  1  fetch address accepted.
- i_data_ok  output  1  fetch data returned.
- i_rdata  output  32  fetch read data.
- d_req  input  1  data request valid.
- d_wr  input  1  1 = store, 0 = load.
- d_size  input  2  0 = byte, 1 = half, 2 = word.
- d_addr  input  32  data address.
- d_wstrb  input  4  byte write strobes.
- d_wdata  input  32  store data.
- d_addr_ok  output  1  data address accepted.
- d_data_ok  output  1  load data returned / store completed.
- d_rdata  output  32  load data.
- m_req  output  1  memory request.
- m_wr  output  1  memory write.
- m_size  output  2  memory access size.
- m_addr  output  32  memory address.
- m_wstrb  output  4  memory strobes.
- m_wdata  output  32  memory write data.
- m_addr_ok  input  1  memory accepted address.
- m_data_ok  input  1  memory returned data / write response.
- m_rdata  input  32  memory read data.
- arb_err  output  1  sticky: data_ok received with no outstanding transaction.

Behaviour:
- FSM states:
  - IDLE: no request on the memory port.
  - HOLD: a request is presented, addr_ok not yet seen. The owner is registered in `grant_d`.
- IDLE:
  - If FIFO is not full and d_req=1: grant d.
  - Else if FIFO is not full and i_req=1: grant i.
  - Fixed priority: d > i.
  - The grant drives m_* combinationally in the same cycle, with m_req=1.
  - If m_addr_ok=1 in that cycle: handshake completes, stay IDLE.
  - Otherwise go to HOLD.
- HOLD:
  - m_req=1 and m_* are sourced from the held owner only. The other requester is not granted.
  - Requesters keep signals stable until their addr_ok.
  - On m_addr_ok=1: go to IDLE.
- Fetch requests drive m_wr=0, m_size=2, m_wstrb=0, m_wdata=0.
- When m_req=0, all m_* fields are 0.
- addr_ok routing: x_addr_ok = m_req & m_addr_ok & (owner==x). At most one of i_addr_ok/d_addr_ok is high per cycle.
- Owner FIFO:
  - Push the owner bit (0 = i, 1 = d) on every m_req & m_addr_ok.
  - Pop on m_data_ok.
  - Circular buffer of depth MAX_OUTSTANDING with a count register; pointers wrap at MAX_OUTSTANDING.
- Full rule: when count==MAX_OUTSTANDING, no new grant from IDLE, even if a pop occurs in the same cycle. HOLD is never entered while full.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- data_ok routing:
  - x_data_ok = m_data_ok & (count!=0) & (head owner==x).
  - i_rdata and d_rdata both equal m_rdata whenever their data_ok is high, and are 0 otherwise.
  - Returns are in order; the memory must return in acceptance order.
- m_data_ok with count==0: no data_ok output, no pop, arb_err set to 1. arb_err stays set until reset.
- Latency: zero added cycles in both the address and data paths (combinational forwarding).
- Reset (synchronous, any cycle including mid-HOLD or with outstanding transactions):
  - state=IDLE, count=0, pointers=0, arb_err=0.
  - All outputs 0 in the cycle after reset.
  - Outstanding transactions are forgotten; a later data_ok for them sets arb_err.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - IDLE priority alternates: a `last_grant` register records the owner of the most recent completed address handshake.
  - On simultaneous d_req and i_req, the requester not equal to last_grant wins.
  - Reset value of last_grant is i, so d wins the first tie.
- Undefined: fixed d > i priority; no last_grant register.

Test Plan:
- Simultaneous d_req (load, addr 0x1000) and i_req (addr 0x1c000000), m_addr_ok=1 always:
  - d_addr_ok in cycle 0 and i_addr_ok in cycle 1.
  - m_data_ok with m_rdata=0xAAAA5555 then 0x12345678 -> d_data_ok/d_rdata=0xAAAA5555, then i_data_ok/i_rdata=0x12345678.
- Hold stability:
  - i_req alone, m_addr_ok=0 for 3 cycles; d_req raised in cycle 1.
  - m_addr stays 0x1c000000 for all 4 cycles.
  - i_addr_ok is set only in cycle 3; d is granted the following cycle.
- Full:
  - MAX_OUTSTANDING=2, two accepted loads, no data_ok; third d_req -> m_req=0.
  - Pulse m_data_ok -> d_data_ok=1. The same cycle still shows m_req=0; the next cycle shows m_req=1.
- Store:
  - d_wr=1, size=0, wstrb=4'b0100, wdata=0x00EF0000, addr 0x2002 -> m_* match the inputs exactly.
  - data_ok returns with d_data_ok=1.
- Spurious and reset:
  - m_data_ok with count 0 -> arb_err=1, no x_data_ok.
  - Reset asserted mid-HOLD -> next cycle m_req=0, arb_err=0, count=0.
- ARB_ROUND_ROBIN_EN defined, d_req and i_req both held high, m_addr_ok=1 -> grants alternate d, i, d, i.
